// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM states,
// parity-mode encodings and the baud increment calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } tx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Rounded phase increment so that the accumulator carries BAUD_RATE times per second
  function automatic longint unsigned calc_inc(input longint unsigned clk_freq,
                                               input longint unsigned baud_rate,
                                               input int unsigned acc_width);
    longint unsigned scaled;
    scaled = baud_rate << acc_width;
    return (scaled + clk_freq / 2) / clk_freq;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Fractional phase-accumulator baud generator; tick is the accumulator carry-out
// while enabled, clr restarts the bit phase at the start of a frame.
module uart_baud_gen #(
  parameter int ACC_WIDTH = 24,
  parameter logic [ACC_WIDTH-1:0] INC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;

  assign sum  = {1'b0, acc} + {1'b0, INC};
  assign tick = en & sum[ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input, per-frame parity and stop
// selection and cts gating. Define UART_TX_FIFO_EN to add the input FIFO.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int ACC_WIDTH  = 24,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  input  logic                          cts,
  output logic                          tx,
  output logic                          baud_tick,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [ACC_WIDTH-1:0] INC =
    ACC_WIDTH'(calc_inc(64'(CLK_FREQ), 64'(BAUD_RATE), ACC_WIDTH));
  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  tx_state_t            state;
  logic [DATA_BITS-1:0] shreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 par_en;
  logic                 par_bit;
  logic                 stop2;
  logic                 stop_second;
  logic                 baud_en;

  logic                 start_frame;
  logic [DATA_BITS-1:0] src_data;
  logic [1:0]           src_mode;
  logic                 src_two_stop;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = DATA_BITS + 3;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LVL_W-1:0]   level;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  // A full FIFO refuses pushes even when a pop happens in the same cycle
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign s_ready = ~full & ~reset;
  assign push    = s_valid & s_ready;
  assign pop     = (state == IDLE) & ~empty & cts & ~reset;

  assign start_frame = pop;
  assign {src_two_stop, src_mode, src_data} = mem[rd_ptr];
  assign fifo_level  = level;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {two_stop, parity_mode, s_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end
`else
  assign s_ready      = (state == IDLE) & cts & ~reset;
  assign start_frame  = s_valid & s_ready;
  assign src_data     = s_data;
  assign src_mode     = parity_mode;
  assign src_two_stop = two_stop;
  assign fifo_level   = '0;
`endif

  assign busy    = (state != IDLE);
  assign baud_en = (state == START) | (state == DATA) | (state == PARITY) | (state == STOP);

  uart_baud_gen #(
    .ACC_WIDTH (ACC_WIDTH),
    .INC       (INC)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .en    (baud_en),
    .clr   (start_frame),
    .tick  (baud_tick)
  );

  // Frame sequencer; the whole frame configuration is latched when the word is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tx          <= 1'b1;
      done        <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      par_en      <= 1'b0;
      par_bit     <= 1'b0;
      stop2       <= 1'b0;
      stop_second <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start_frame) begin
            state   <= START;
            tx      <= 1'b0;
            shreg   <= src_data;
            par_en  <= (src_mode == PAR_EVEN) || (src_mode == PAR_ODD);
            par_bit <= (^src_data) ^ (src_mode == PAR_ODD);
            stop2   <= src_two_stop;
          end
        end
        START: begin
          if (baud_tick) begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == LAST_BIT) begin
              stop_second <= 1'b0;
              if (par_en) begin
                state <= PARITY;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            state       <= STOP;
            tx          <= 1'b1;
            stop_second <= 1'b0;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (stop2 && !stop_second) begin
              stop_second <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
